// File: rtl/nts_ip_udp_locate_ctrl_pkg.sv
// Shared definitions for the UDP payload locator: sequencer states, drop
// reason codes and the parser opcodes it issues.
package nts_ip_udp_locate_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_OFFSET = 3'd1,
        ST_RD_LENGTH = 3'd2,
        ST_CHECK     = 3'd3,
        ST_OFFER     = 3'd4,
        ST_DROP      = 3'd5
    } state_e;

    localparam logic [2:0] DROP_NONE       = 3'd0;
    localparam logic [2:0] DROP_NOT_IPV4   = 3'd1;
    localparam logic [2:0] DROP_BAD_IHL    = 3'd2;
    localparam logic [2:0] DROP_UDP_SHORT  = 3'd3;
    localparam logic [2:0] DROP_UDP_BEYOND = 3'd4;

    // Opcode values are shared with the IP header parser's read mux.
    localparam int unsigned OPCODE_GET_OFFSET_UDP_DATA = 0;
    localparam int unsigned OPCODE_GET_LENGTH_UDP      = 1;

    localparam int unsigned UDP_HEADER_BYTES = 8;

endpackage

// File: rtl/nts_sat_counter32.sv
// 32-bit statistics counter: adds 0..2 per cycle, sticks at all-ones,
// with synchronous clear and a synchronous load.
module nts_sat_counter32 (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [31:0] i_load_value,
    input  logic [1:0]  i_inc,
    output logic [31:0] o_count
);

    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [32:0] sum;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Clear wins over an increment arriving in the same cycle.
    always_comb begin
        sum     = {1'b0, count_q} + {31'b0, i_inc};
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_load_value;
        end else if (sum[32]) begin
            count_d = '1;
        end else begin
            count_d = sum[31:0];
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/nts_ip_udp_locate_ctrl.sv
// Locates the UDP payload of a parsed frame: reads offset/length from the IP
// parser, bounds-checks them against the frame and offers or drops it.
module nts_ip_udp_locate_ctrl
    import nts_ip_udp_locate_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH      = 10,
    parameter int IP_OPCODE_WIDTH = 4,
    parameter int MIN_UDP_PAYLOAD = 48
) (
    input  logic                       i_clk,
    input  logic                       i_areset,
    input  logic                       i_clear,
    input  logic                       i_clear_counters,
    input  logic                       i_frame_done,
    input  logic [ADDR_WIDTH+2:0]      i_frame_bytes,
    input  logic                       i_detect_ipv4,
    input  logic                       i_detect_ipv4_bad,
    output logic [IP_OPCODE_WIDTH-1:0] o_ip_read_opcode,
    input  logic [31:0]                i_ip_read_data,
    output logic                       o_udp_valid,
    input  logic                       i_udp_ready,
    output logic [ADDR_WIDTH+2:0]      o_udp_payload_offset,
    output logic [15:0]                o_udp_payload_length,
    output logic                       o_drop,
    output logic [2:0]                 o_drop_reason,
    output logic                       o_overrun,
    output logic                       o_busy,
    output logic [31:0]                o_accept_count,
    output logic [31:0]                o_drop_count
);

    localparam int BW = ADDR_WIDTH + 3;
    localparam logic [16:0] MIN_UDP_LEN = 17'(UDP_HEADER_BYTES + MIN_UDP_PAYLOAD);

    state_e        state_q, state_d;
    logic [BW-1:0] frame_bytes_q, frame_bytes_d;
    logic [BW-1:0] udp_offset_q, udp_offset_d;
    logic [15:0]   udp_len_q, udp_len_d;
    logic [BW-1:0] payload_offset_q, payload_offset_d;
    logic [15:0]   payload_length_q, payload_length_d;
    logic [2:0]    drop_reason_q, drop_reason_d;

    logic [16:0]   udp_end;
    logic          accept;
    logic [1:0]    drop_inc;
    logic          read_data_unused;

    assign read_data_unused = ^i_ip_read_data[31:16];

    // State register
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q          <= ST_IDLE;
            frame_bytes_q    <= '0;
            udp_offset_q     <= '0;
            udp_len_q        <= '0;
            payload_offset_q <= '0;
            payload_length_q <= '0;
            drop_reason_q    <= DROP_NONE;
        end else begin
            state_q          <= state_d;
            frame_bytes_q    <= frame_bytes_d;
            udp_offset_q     <= udp_offset_d;
            udp_len_q        <= udp_len_d;
            payload_offset_q <= payload_offset_d;
            payload_length_q <= payload_length_d;
            drop_reason_q    <= drop_reason_d;
        end
    end

    // Next-state and capture logic
    always_comb begin
        state_d          = state_q;
        frame_bytes_d    = frame_bytes_q;
        udp_offset_d     = udp_offset_q;
        udp_len_d        = udp_len_q;
        payload_offset_d = payload_offset_q;
        payload_length_d = payload_length_q;
        drop_reason_d    = drop_reason_q;
        // 17-bit sum: offset + length can never wrap before the comparison.
        udp_end          = 17'(udp_offset_q) + {1'b0, udp_len_q};

        case (state_q)
            ST_IDLE: begin
                if (i_frame_done) begin
                    frame_bytes_d = i_frame_bytes;
                    if (!i_detect_ipv4) begin
                        state_d       = ST_DROP;
                        drop_reason_d = DROP_NOT_IPV4;
                    end else if (i_detect_ipv4_bad) begin
                        state_d       = ST_DROP;
                        drop_reason_d = DROP_BAD_IHL;
                    end else begin
                        state_d = ST_RD_OFFSET;
                    end
                end
            end
            ST_RD_OFFSET: begin
                udp_offset_d = i_ip_read_data[BW-1:0];
                state_d      = ST_RD_LENGTH;
            end
            ST_RD_LENGTH: begin
                udp_len_d = i_ip_read_data[15:0];
                state_d   = ST_CHECK;
            end
            ST_CHECK: begin
                if ({1'b0, udp_len_q} < MIN_UDP_LEN) begin
                    state_d       = ST_DROP;
                    drop_reason_d = DROP_UDP_SHORT;
                end else if (udp_end > 17'(frame_bytes_q)) begin
                    state_d       = ST_DROP;
                    drop_reason_d = DROP_UDP_BEYOND;
                end else begin
                    state_d          = ST_OFFER;
                    payload_offset_d = udp_offset_q + BW'(UDP_HEADER_BYTES);
                    payload_length_d = udp_len_q - 16'(UDP_HEADER_BYTES);
                end
            end
            ST_OFFER: begin
                if (i_udp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort keeps the last drop reason visible but forgets the frame.
        if (i_clear) begin
            state_d          = ST_IDLE;
            frame_bytes_d    = '0;
            udp_offset_d     = '0;
            udp_len_d        = '0;
            payload_offset_d = '0;
            payload_length_d = '0;
            drop_reason_d    = drop_reason_q;
        end
    end

    // Output decode
    always_comb begin
        o_busy               = (state_q != ST_IDLE);
        o_udp_valid          = (state_q == ST_OFFER);
        o_drop               = (state_q == ST_DROP);
        o_drop_reason        = drop_reason_q;
        o_udp_payload_offset = payload_offset_q;
        o_udp_payload_length = payload_length_q;
        o_overrun            = i_frame_done && (state_q != ST_IDLE) && !i_clear;
        if (state_q == ST_RD_LENGTH) begin
            o_ip_read_opcode = IP_OPCODE_WIDTH'(OPCODE_GET_LENGTH_UDP);
        end else begin
            o_ip_read_opcode = IP_OPCODE_WIDTH'(OPCODE_GET_OFFSET_UDP_DATA);
        end
        accept   = o_udp_valid && i_udp_ready;
        drop_inc = {1'b0, o_drop} + {1'b0, o_overrun};
    end

    nts_sat_counter32 u_accept_count (
        .i_clk        (i_clk),
        .i_areset     (i_areset),
        .i_clear      (i_clear_counters),
        .i_load       (1'b0),
        .i_load_value (32'd0),
        .i_inc        ({1'b0, accept}),
        .o_count      (o_accept_count)
    );

    nts_sat_counter32 u_drop_count (
        .i_clk        (i_clk),
        .i_areset     (i_areset),
        .i_clear      (i_clear_counters),
        .i_load       (1'b0),
        .i_load_value (32'd0),
        .i_inc        (drop_inc),
        .o_count      (o_drop_count)
    );

endmodule

// File: tb/tb_nts_ip_udp_locate_ctrl.sv
// Bench for nts_ip_udp_locate_ctrl: directed and randomized frames against a
// rule-level model of the locate/validate decision.
module tb_nts_ip_udp_locate_ctrl;
  localparam int AW   = 10;
  localparam int OW   = 4;
  localparam int MINP = 48;
  localparam int BW   = AW + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_areset, i_clear, i_clear_counters, i_frame_done;
  logic [BW-1:0] i_frame_bytes;
  logic          i_detect_ipv4, i_detect_ipv4_bad;
  logic [OW-1:0] o_ip_read_opcode;
  logic [31:0]   i_ip_read_data;
  logic          o_udp_valid, i_udp_ready;
  logic [BW-1:0] o_udp_payload_offset;
  logic [15:0]   o_udp_payload_length;
  logic          o_drop;
  logic [2:0]    o_drop_reason;
  logic          o_overrun, o_busy;
  logic [31:0]   o_accept_count, o_drop_count;

  logic [31:0]   par_off, par_len;
  int            op1_cycles;

  logic          sat_clear, sat_load;
  logic [31:0]   sat_load_value, sat_count;
  logic [1:0]    sat_inc;

  int checks, errors;
  int exp_acc, exp_drop;

  nts_ip_udp_locate_ctrl #(.ADDR_WIDTH(AW), .IP_OPCODE_WIDTH(OW), .MIN_UDP_PAYLOAD(MINP)) dut (
    .i_clk(clk), .i_areset(i_areset), .i_clear(i_clear), .i_clear_counters(i_clear_counters),
    .i_frame_done(i_frame_done), .i_frame_bytes(i_frame_bytes),
    .i_detect_ipv4(i_detect_ipv4), .i_detect_ipv4_bad(i_detect_ipv4_bad),
    .o_ip_read_opcode(o_ip_read_opcode), .i_ip_read_data(i_ip_read_data),
    .o_udp_valid(o_udp_valid), .i_udp_ready(i_udp_ready),
    .o_udp_payload_offset(o_udp_payload_offset), .o_udp_payload_length(o_udp_payload_length),
    .o_drop(o_drop), .o_drop_reason(o_drop_reason), .o_overrun(o_overrun), .o_busy(o_busy),
    .o_accept_count(o_accept_count), .o_drop_count(o_drop_count)
  );

  nts_sat_counter32 u_sat (
    .i_clk(clk), .i_areset(i_areset), .i_clear(sat_clear), .i_load(sat_load),
    .i_load_value(sat_load_value), .i_inc(sat_inc), .o_count(sat_count)
  );

  // Parser model: read data follows the opcode combinationally.
  always_comb i_ip_read_data = (o_ip_read_opcode == 4'd1) ? par_len : par_off;

  always @(posedge clk or posedge i_areset) begin
    if (i_areset) op1_cycles <= 0;
    else if (o_ip_read_opcode == 4'd1) op1_cycles <= op1_cycles + 1;
  end

  // Reference decision: 0 = accept, else drop reason.
  function automatic int ref_reason(input bit v4, input bit bad, input int fb,
                                    input logic [31:0] offw, input logic [31:0] lenw);
    int off, len;
    off = int'(offw[BW-1:0]);
    len = int'(lenw[15:0]);
    if (!v4) return 1;
    if (bad) return 2;
    if (len < 8 + MINP) return 3;
    if (off + len > fb) return 4;
    return 0;
  endfunction

  task automatic drive_idle();
    i_clear = 0; i_clear_counters = 0; i_frame_done = 0; i_frame_bytes = '0;
    i_detect_ipv4 = 0; i_detect_ipv4_bad = 0; i_udp_ready = 0;
    par_off = '0; par_len = '0;
    sat_clear = 0; sat_load = 0; sat_load_value = '0; sat_inc = '0;
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (o_accept_count !== 32'(exp_acc)) begin
      errors++; $display("FAIL %s accept_count got %0d exp %0d", tag, o_accept_count, exp_acc);
    end
    checks++;
    if (o_drop_count !== 32'(exp_drop)) begin
      errors++; $display("FAIL %s drop_count got %0d exp %0d", tag, o_drop_count, exp_drop);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    i_areset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_udp_valid, o_drop, o_overrun, o_drop_reason, o_ip_read_opcode} !== '0) begin
      errors++; $display("FAIL reset_ctrl got %0h exp 0",
                         {o_busy, o_udp_valid, o_drop, o_overrun, o_drop_reason, o_ip_read_opcode});
    end
    checks++;
    if ({o_udp_payload_offset, o_udp_payload_length, o_accept_count, o_drop_count} !== '0) begin
      errors++; $display("FAIL reset_data got %0h exp 0",
                         {o_udp_payload_offset, o_udp_payload_length, o_accept_count, o_drop_count});
    end
    i_areset = 0;
    exp_acc = 0; exp_drop = 0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_idle got %0d exp 0", o_busy); end
  endtask

  // Sends one frame and follows it to completion, checking cycle timing.
  task automatic send_frame(input bit v4, input bit bad, input int fb,
                            input logic [31:0] offw, input logic [31:0] lenw, input int rdy_wait);
    int reason, eoff, elen, op1_before;
    reason = ref_reason(v4, bad, fb, offw, lenw);
    eoff = (int'(offw[BW-1:0]) + 8) % (1 << BW);
    elen = int'(lenw[15:0]) - 8;
    op1_before = op1_cycles;
    @(negedge clk);
    i_frame_done = 1; i_frame_bytes = BW'(fb);
    i_detect_ipv4 = v4; i_detect_ipv4_bad = bad; par_off = offw; par_len = lenw;
    @(negedge clk);
    i_frame_done = 0;
    if (reason == 1 || reason == 2) begin
      checks++;
      if (o_drop !== 1'b1 || o_drop_reason !== 3'(reason)) begin
        errors++; $display("FAIL early_drop got drop %0d reason %0d exp drop 1 reason %0d", o_drop, o_drop_reason, reason);
      end
      exp_drop++;
      @(negedge clk);
      checks++;
      if (o_drop !== 1'b0 || o_busy !== 1'b0) begin
        errors++; $display("FAIL early_drop_end got drop %0d busy %0d exp 0 0", o_drop, o_busy);
      end
      checks++;
      if (op1_cycles !== op1_before) begin
        errors++; $display("FAIL early_drop_opcode got %0d length reads exp 0", op1_cycles - op1_before);
      end
      check_counts("early_drop");
    end else begin
      checks++;
      if (o_busy !== 1'b1 || o_ip_read_opcode !== 4'd0) begin
        errors++; $display("FAIL rd_offset got busy %0d opcode %0d exp 1 0", o_busy, o_ip_read_opcode);
      end
      @(negedge clk);
      checks++;
      if (o_ip_read_opcode !== 4'd1) begin
        errors++; $display("FAIL rd_length opcode got %0d exp 1", o_ip_read_opcode);
      end
      @(negedge clk);
      checks++;
      if (o_udp_valid !== 1'b0 || o_drop !== 1'b0) begin
        errors++; $display("FAIL check_cycle got valid %0d drop %0d exp 0 0", o_udp_valid, o_drop);
      end
      @(negedge clk);
      if (reason != 0) begin
        checks++;
        if (o_drop !== 1'b1 || o_drop_reason !== 3'(reason) || o_udp_valid !== 1'b0) begin
          errors++; $display("FAIL late_drop got drop %0d reason %0d exp drop 1 reason %0d", o_drop, o_drop_reason, reason);
        end
        exp_drop++;
        @(negedge clk);
        checks++;
        if (o_drop !== 1'b0 || o_busy !== 1'b0) begin
          errors++; $display("FAIL late_drop_end got drop %0d busy %0d exp 0 0", o_drop, o_busy);
        end
        check_counts("late_drop");
      end else begin
        checks++;
        if (o_udp_valid !== 1'b1 || o_udp_payload_offset !== BW'(eoff) || o_udp_payload_length !== 16'(elen)) begin
          errors++; $display("FAIL offer got valid %0d off %0d len %0d exp 1 %0d %0d",
                             o_udp_valid, o_udp_payload_offset, o_udp_payload_length, eoff, elen);
        end
        for (int i = 0; i < rdy_wait; i++) begin
          @(negedge clk);
          checks++;
          if (o_udp_valid !== 1'b1 || o_udp_payload_offset !== BW'(eoff) || o_udp_payload_length !== 16'(elen)) begin
            errors++; $display("FAIL offer_hold got valid %0d off %0d len %0d exp 1 %0d %0d",
                               o_udp_valid, o_udp_payload_offset, o_udp_payload_length, eoff, elen);
          end
        end
        i_udp_ready = 1;
        @(negedge clk);
        i_udp_ready = 0;
        exp_acc++;
        checks++;
        if (o_udp_valid !== 1'b0 || o_busy !== 1'b0) begin
          errors++; $display("FAIL offer_end got valid %0d busy %0d exp 0 0", o_udp_valid, o_busy);
        end
        check_counts("accept");
      end
    end
  endtask

  task automatic test_directed();
    send_frame(1, 0, 98, 32'd42, 32'd56, 2);
    send_frame(0, 0, 98, 32'd42, 32'd56, 0);
    send_frame(1, 1, 98, 32'd42, 32'd56, 0);
    send_frame(1, 0, 98, 32'd42, 32'd64, 0);
    send_frame(1, 0, 98, 32'd42, 32'd55, 0);
    send_frame(1, 0, 98, 32'd42, 32'd56, 0);
    send_frame(1, 0, 97, 32'd42, 32'd56, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      bit v4, bad;
      logic [31:0] offw, lenw;
      v4   = ($urandom_range(0, 9) != 0);
      bad  = ($urandom_range(0, 7) == 0);
      offw = {19'($urandom), 13'($urandom_range(14, 90))};
      lenw = {16'($urandom), 16'($urandom_range(40, 200))};
      send_frame(v4, bad, int'($urandom_range(40, 300)), offw, lenw, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    i_frame_done = 1; i_frame_bytes = 13'd98; i_detect_ipv4 = 1; i_detect_ipv4_bad = 0;
    par_off = 32'd42; par_len = 32'd56;
    @(negedge clk);
    i_frame_done = 0;
    @(negedge clk);
    i_frame_done = 1; i_frame_bytes = 13'd5;
    #1;
    checks++;
    if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got %0d exp 1", o_overrun); end
    exp_drop++;
    @(negedge clk);
    i_frame_done = 0;
    #1;
    checks++;
    if (o_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %0d exp 0", o_overrun); end
    @(negedge clk);
    checks++;
    if (o_udp_valid !== 1'b1 || o_udp_payload_offset !== 13'd50 || o_udp_payload_length !== 16'd48) begin
      errors++; $display("FAIL overrun_first_frame got valid %0d off %0d len %0d exp 1 50 48",
                         o_udp_valid, o_udp_payload_offset, o_udp_payload_length);
    end
    i_udp_ready = 1;
    @(negedge clk);
    i_udp_ready = 0;
    exp_acc++;
    check_counts("overrun");
    // Drop pulse and overrun in the same cycle count twice.
    i_frame_done = 1; i_detect_ipv4 = 0;
    @(negedge clk);
    #1;
    checks++;
    if (o_drop !== 1'b1 || o_overrun !== 1'b1) begin
      errors++; $display("FAIL drop_and_overrun got drop %0d overrun %0d exp 1 1", o_drop, o_overrun);
    end
    exp_drop += 2;
    @(negedge clk);
    i_frame_done = 0;
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL overrun_ignored busy got %0d exp 0", o_busy); end
    check_counts("drop_and_overrun");
  endtask

  task automatic test_clear();
    @(negedge clk);
    i_frame_done = 1; i_frame_bytes = 13'd98; i_detect_ipv4 = 1; i_detect_ipv4_bad = 0;
    par_off = 32'd42; par_len = 32'd56;
    @(negedge clk);
    i_frame_done = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_udp_valid !== 1'b1) begin errors++; $display("FAIL clear_setup valid got %0d exp 1", o_udp_valid); end
    i_clear = 1;
    @(negedge clk);
    i_clear = 0;
    checks++;
    if (o_udp_valid !== 1'b0 || o_busy !== 1'b0 || o_udp_payload_offset !== '0 || o_udp_payload_length !== '0) begin
      errors++; $display("FAIL clear_offer got valid %0d busy %0d off %0d len %0d exp 0 0 0 0",
                         o_udp_valid, o_busy, o_udp_payload_offset, o_udp_payload_length);
    end
    check_counts("clear_offer");
    // Clear beats a simultaneous frame_done.
    i_clear = 1; i_frame_done = 1; i_detect_ipv4 = 0;
    #1;
    checks++;
    if (o_overrun !== 1'b0) begin errors++; $display("FAIL clear_vs_done overrun got %0d exp 0", o_overrun); end
    @(negedge clk);
    i_clear = 0; i_frame_done = 0;
    checks++;
    if (o_busy !== 1'b0 || o_drop !== 1'b0) begin
      errors++; $display("FAIL clear_vs_done got busy %0d drop %0d exp 0 0", o_busy, o_drop);
    end
    @(negedge clk);
    check_counts("clear_vs_done");
    // Counter clear beats the drop increment of the same cycle.
    i_frame_done = 1; i_detect_ipv4 = 0;
    @(negedge clk);
    i_frame_done = 0; i_clear_counters = 1;
    @(negedge clk);
    i_clear_counters = 0;
    exp_acc = 0; exp_drop = 0;
    check_counts("clear_counters");
  endtask

  task automatic test_areset();
    send_frame(0, 0, 98, 32'd42, 32'd56, 0);
    @(negedge clk);
    i_frame_done = 1; i_frame_bytes = 13'd98; i_detect_ipv4 = 1; i_detect_ipv4_bad = 0;
    par_off = 32'd42; par_len = 32'd56;
    @(negedge clk);
    i_frame_done = 0;
    @(negedge clk);
    #2;
    i_areset = 1;
    #1;
    exp_acc = 0; exp_drop = 0;
    checks++;
    if ({o_busy, o_udp_valid, o_drop, o_drop_reason, o_ip_read_opcode} !== '0) begin
      errors++; $display("FAIL areset_mid got %0h exp 0", {o_busy, o_udp_valid, o_drop, o_drop_reason, o_ip_read_opcode});
    end
    check_counts("areset_mid");
    @(negedge clk);
    i_areset = 0;
    send_frame(1, 0, 98, 32'd42, 32'd56, 1);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    sat_load = 1; sat_load_value = 32'hFFFF_FFFE;
    @(negedge clk);
    sat_load = 0; sat_inc = 2'd2;
    @(negedge clk);
    sat_inc = 2'd0;
    checks++;
    if (sat_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_plus2 got %0h exp ffffffff", sat_count); end
    sat_inc = 2'd1;
    @(negedge clk);
    sat_inc = 2'd0;
    checks++;
    if (sat_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %0h exp ffffffff", sat_count); end
    sat_load = 1; sat_load_value = 32'hFFFF_FFFC;
    @(negedge clk);
    sat_load = 0; sat_inc = 2'd2;
    @(negedge clk);
    sat_inc = 2'd1;
    checks++;
    if (sat_count !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_below got %0h exp fffffffe", sat_count); end
    @(negedge clk);
    sat_inc = 2'd2; sat_clear = 1;
    checks++;
    if (sat_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach got %0h exp ffffffff", sat_count); end
    @(negedge clk);
    sat_inc = 2'd0; sat_clear = 0;
    checks++;
    if (sat_count !== 32'd0) begin errors++; $display("FAIL sat_clear got %0h exp 0", sat_count); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_directed();
    test_overrun();
    test_clear();
    test_random();
    test_areset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/nts_ip_udp_locate_ctrl.md
# nts_ip_udp_locate_ctrl

Sequencer that sits between the receive buffer's frame-complete event and the IP header parser's opcode read port. It reads the parser's IPv4 verdict, then the UDP data offset and UDP length, and validates them against the received frame length. It then either offers a UDP payload descriptor (byte offset and length) to the downstream NTS/NTP stage over a valid/ready handshake, or drops the frame with a reason code. It also keeps saturating accept/drop statistics.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-address width of the receive buffer; byte offsets are ADDR_WIDTH+3 bits; ADDR_WIDTH ≤ 13 required.
- IP_OPCODE_WIDTH, 4: width of the parser read opcode.
- MIN_UDP_PAYLOAD, 48: minimum accepted UDP payload bytes (NTP header).

Ports:
- Clock and reset (already decided): reset i_areset, asynchronous, active-high; clock i_clk.
- i_clear, in, 1: synchronous abort to IDLE; counters kept.
- i_clear_counters, in, 1: synchronous counter clear.
- i_frame_done, in, 1: one-cycle pulse; the frame is fully parsed.
- i_frame_bytes, in, ADDR_WIDTH+3: total received frame bytes, valid with i_frame_done.
- i_detect_ipv4, in, 1: parser IPv4 detect.
- i_detect_ipv4_bad, in, 1: parser IPv4 with IHL≠5.
- o_ip_read_opcode, out, IP_OPCODE_WIDTH: parser opcode (0 = UDP data offset, 1 = UDP length).
- i_ip_read_data, in, 32: parser read data, combinational from the opcode.
- o_udp_valid, out, 1: descriptor valid.
- i_udp_ready, in, 1: downstream accept.
- o_udp_payload_offset, out, ADDR_WIDTH+3: byte offset of UDP payload (UDP data offset + 8).
- o_udp_payload_length, out, 16: UDP length − 8.
- o_drop, out, 1: one-cycle drop pulse.
- o_drop_reason, out, 3: reason, held until the next drop.
- o_overrun, out, 1: pulse; i_frame_done arrived while not IDLE.
- o_busy, out, 1: state ≠ IDLE.
- o_accept_count, out, 32: saturating count of accepted descriptors.
- o_drop_count, out, 32: saturating count of drops and overruns.

## Operation
- States:
  - IDLE: o_ip_read_opcode=0. On i_frame_done, latch i_frame_bytes; if !i_detect_ipv4 → DROP(1); else if i_detect_ipv4_bad → DROP(2); else → RD_OFFSET.
  - RD_OFFSET: opcode=0; capture i_ip_read_data[ADDR_WIDTH+2:0] as udp_offset; → RD_LENGTH.
  - RD_LENGTH: opcode=1; capture i_ip_read_data[15:0] as udp_len; → CHECK.
  - CHECK: if udp_len < 8+MIN_UDP_PAYLOAD → DROP(3); else if udp_offset+udp_len > frame_bytes → DROP(4); else → OFFER.
  - OFFER: o_udp_valid=1, descriptor stable; when i_udp_ready, increment accept_count → IDLE.
  - DROP: o_drop=1 for one cycle, o_drop_reason updated → IDLE.
- Reason codes: 0 none, 1 not IPv4, 2 bad IHL, 3 UDP too short, 4 UDP beyond frame.
- Arithmetic: the bounds check uses 17-bit zero-extended addition, so it cannot wrap. Payload offset = udp_offset+8, truncated to ADDR_WIDTH+3 bits. It cannot overflow once the check passes.
- Overrun: i_frame_done in any non-IDLE state → o_overrun pulse; the frame is ignored and the current sequence continues.
- drop_count increments by o_drop+o_overrun (0..2) per cycle and saturates at 2^32−1. accept_count also saturates.
- i_clear: → IDLE, o_udp_valid low, captured registers zeroed; i_clear beats a simultaneous i_frame_done (no overrun, no drop). i_clear_counters beats a simultaneous increment.

## Timing
- Reset values: every output 0; state IDLE.
- i_frame_done at cycle T:
  - RD_OFFSET at T+1, RD_LENGTH at T+2, CHECK at T+3.
  - o_udp_valid or o_drop at T+4.
  - Immediate drops (reasons 1 and 2): o_drop at T+1.
- Handshake: o_udp_valid stays high with a stable descriptor until the cycle with i_udp_ready; it drops the next cycle. A new frame can be accepted the cycle after return to IDLE.
- o_ip_read_opcode is decoded combinationally from state; the parser read path is combinational, so capture happens in the same cycle.

## Structure
- A shared package holds: the state encoding, the drop reason constants, and the opcode constants (OPCODE_GET_OFFSET_UDP_DATA=0, OPCODE_GET_LENGTH_UDP=1), common with the parser.
- One sub-module, nts_sat_counter32: 32-bit saturating counter with clear and 0..2 increment, instantiated twice.

## Test plan
- IPv4 accept: i_frame_done with frame_bytes=98, detect_ipv4=1; parser returns offset 42, length 56 → at T+4 o_udp_valid, offset 50, length 48; ready at T+6 → valid low T+7, accept_count=1.
- Not IPv4: detect_ipv4=0 → o_drop at T+1, reason 1, drop_count=1, opcode never 1.
- Bounds: offset 42, length 64, frame_bytes 98 → o_drop at T+4, reason 4. Repeat with length 55 → reason 3.
- Overrun: second i_frame_done at T+2 → o_overrun at T+2; first frame completes normally; drop_count +1.
- Abort and reset: i_clear during OFFER → valid low next cycle, state IDLE, counters held. i_areset mid-RD_LENGTH → all outputs 0 immediately.
- Saturation: preload drop_count to 2^32−2, then a drop and an overrun in the same cycle → count 2^32−1.
